// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALU operations and datapath mux selects, used by the controller, alu and datapath.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SR  = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:     return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an ALUOp class plus funct fields to the alu operation and its qualifiers.
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       rtype,
  output logic [2:0] alu_control,
  output logic       funct3_bit,
  output logic       funct7b6
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SR;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // The alu expects 1 for logical shift, so the qualifier is the inverse of bit 30.
  assign funct3_bit = funct3[0];
  assign funct7b6   = ~funct7b5;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: steps each instruction through its states and
// drives datapath selects, write enables and the alu operation.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       funct3_bit,
  output logic       funct7b6
);

  state_t state_reg, state_next;
  aluop_t aluop;
  logic   pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw;
  logic   branch_taken;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  // Only beq/bne are resolved; other branch funct3 values fall through untaken.
  assign branch_taken = (funct3[2:1] == 2'b00) && (Zero ^ funct3[0]);

  always_comb begin
    state_next   = S_FETCH;
    pcwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    aluop        = ALUOP_ADD;
    case (state_reg)
      S_FETCH: begin
        state_next  = S_DECODE;
        irwrite_raw = 1'b1;
        pcwrite_raw = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTER;
          OP_ITYPE:     state_next = S_EXECUTEI;
          OP_BRANCH:    state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_next = S_MEMWB;
        AdrSrc     = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTER: begin
        state_next = S_ALUWB;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        aluop      = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        state_next = S_ALUWB;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite_raw = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = SRCB_RS2;
        aluop       = ALUOP_SUB;
        pcwrite_raw = branch_taken;
      end
      S_JAL: begin
        state_next  = S_ALUWB;
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        pcwrite_raw = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Architectural writes are suppressed for the whole reset cycle, whatever the state.
  assign PCWrite  = pcwrite_raw  & ~reset;
  assign MemWrite = memwrite_raw & ~reset;
  assign IRWrite  = irwrite_raw  & ~reset;
  assign RegWrite = regwrite_raw & ~reset;
  assign ImmSrc   = imm_src_of(op);

  alu_op_decoder u_alu_op_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .rtype      (state_reg == S_EXECUTER),
    .alu_control(ALUControl),
    .funct3_bit (funct3_bit),
    .funct7b6   (funct7b6)
  );

endmodule
